// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit: FSM states,
// datapath mux selects, opcode/command/condition codes and the cmd-to-ALU map.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    function automatic logic [1:0] cmd_to_alu(input logic [3:0] cmd);
        logic [1:0] alu;
        case (cmd)
            CMD_ADD: alu = ALU_ADD;
            CMD_SUB: alu = ALU_SUB;
            CMD_CMP: alu = ALU_SUB;
            CMD_AND: alu = ALU_AND;
            CMD_ORR: alu = ALU_ORR;
            default: alu = ALU_ADD;
        endcase
        return alu;
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Control interface between mc_controller (master) and the multicycle datapath (slave).
interface mc_controller_if;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        MemWrite;
    logic        RegWrite;
    logic        IRWrite;
    logic        AdrSrc;
    logic [1:0]  RegSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [1:0]  ALUControl;
    logic [3:0]  StateDbg;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ImmSrc, ALUControl, StateDbg
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ImmSrc, ALUControl, StateDbg
    );
endinterface

// File: rtl/mc_condlogic.sv
// NZCV flag register, ARM condition evaluation and the latched condition result
// that qualifies the write-back states of the current instruction.
module mc_condlogic
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       flag_we,
    input  logic       cond_capture,
    output logic       cond_ex,
    output logic       cond_ex_r
);

    logic [3:0] flags_r;
    logic       n_s, z_s, c_s, v_s;

    assign {n_s, z_s, c_s, v_s} = flags_r;

    // condition check against the current flags
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z_s;
            COND_NE: cond_ex = ~z_s;
            COND_CS: cond_ex = c_s;
            COND_CC: cond_ex = ~c_s;
            COND_MI: cond_ex = n_s;
            COND_PL: cond_ex = ~n_s;
            COND_VS: cond_ex = v_s;
            COND_VC: cond_ex = ~v_s;
            COND_HI: cond_ex = c_s & ~z_s;
            COND_LS: cond_ex = ~c_s | z_s;
            COND_GE: cond_ex = (n_s == v_s);
            COND_LT: cond_ex = (n_s != v_s);
            COND_GT: cond_ex = ~z_s & (n_s == v_s);
            COND_LE: cond_ex = z_s | (n_s != v_s);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // flag register (all four bits written together) and latched condition
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_r   <= 4'b0000;
            cond_ex_r <= 1'b0;
        end else begin
            if (flag_we) begin
                flags_r <= alu_flags;
            end
            if (cond_capture) begin
                cond_ex_r <= cond_ex;
            end
        end
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit for the ARM-subset datapath: Moore main FSM, decoder
// and condition logic. Define MC_CMP_EN to execute CMP (cmd 1010) instead of a NOP.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    mc_controller_if.master       bus
);

    logic [3:0] cond_s;
    logic [1:0] op_s;
    logic       i_bit_s;
    logic [3:0] cmd_s;
    logic       s_bit_s;
    logic       u_bit_s;
    logic       l_bit_s;
    logic [3:0] rd_s;
    logic       rd_pc_s;
    logic       unused_rn_s;
    logic       is_cmp_s;
    logic       supported_s;
    logic [1:0] dp_alu_s;

    state_t     state_r;
    state_t     next_s;
    logic       pc_write_s;
    logic       mem_write_s;
    logic       reg_write_s;
    logic       ir_write_s;
    logic       adr_src_s;
    logic       alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_ctl_s;
    logic [1:0] imm_src_s;
    logic       flag_we_s;
    logic       cond_capture_s;
    logic       cond_ex_s;
    logic       cond_ex_r;

    // Instr carries instruction bits [31:12]
    assign cond_s      = bus.Instr[19:16];
    assign op_s        = bus.Instr[15:14];
    assign i_bit_s     = bus.Instr[13];
    assign cmd_s       = bus.Instr[12:9];
    assign s_bit_s     = bus.Instr[8];
    assign u_bit_s     = bus.Instr[11];
    assign l_bit_s     = bus.Instr[8];
    assign rd_s        = bus.Instr[3:0];
    assign rd_pc_s     = (rd_s == 4'd15);
    assign unused_rn_s = ^bus.Instr[7:4];
    assign dp_alu_s    = cmd_to_alu(cmd_s);

`ifdef MC_CMP_EN
    assign is_cmp_s = (op_s == OP_DP) && (cmd_s == CMD_CMP);
`else
    assign is_cmp_s = 1'b0;
`endif

    // instruction support check; anything else retires as a NOP
    always_comb begin
        supported_s = 1'b0;
        case (op_s)
            OP_DP:   supported_s = (cmd_s == CMD_ADD) || (cmd_s == CMD_SUB) ||
                                   (cmd_s == CMD_AND) || (cmd_s == CMD_ORR) || is_cmp_s;
            OP_MEM:  supported_s = 1'b1;
            OP_BR:   supported_s = 1'b1;
            default: supported_s = 1'b0;
        endcase
    end

    // immediate format follows the opcode
    always_comb begin
        imm_src_s = 2'b11;
        case (op_s)
            OP_DP:   imm_src_s = IMM_8;
            OP_MEM:  imm_src_s = IMM_12;
            OP_BR:   imm_src_s = IMM_24;
            default: imm_src_s = 2'b11;
        endcase
    end

    mc_condlogic u_condlogic (
        .clk          (clk),
        .reset        (reset),
        .cond         (cond_s),
        .alu_flags    (bus.ALUFlags),
        .flag_we      (flag_we_s),
        .cond_capture (cond_capture_s),
        .cond_ex      (cond_ex_s),
        .cond_ex_r    (cond_ex_r)
    );

    // main FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // next-state and Moore control decode
    always_comb begin
        next_s         = FETCH;
        pc_write_s     = 1'b0;
        mem_write_s    = 1'b0;
        reg_write_s    = 1'b0;
        ir_write_s     = 1'b0;
        adr_src_s      = 1'b0;
        alu_src_a_s    = 1'b0;
        alu_src_b_s    = SRCB_REG;
        result_src_s   = RES_ALUOUT;
        alu_ctl_s      = ALU_ADD;
        flag_we_s      = 1'b0;
        cond_capture_s = 1'b0;
        case (state_r)
            FETCH: begin
                ir_write_s   = 1'b1;
                alu_src_a_s  = 1'b1;
                alu_src_b_s  = SRCB_FOUR;
                result_src_s = RES_ALURESULT;
                pc_write_s   = 1'b1;
                next_s       = DECODE;
            end
            DECODE: begin
                // PC+4 again gives PC+8 on Result for R15 reads
                alu_src_a_s    = 1'b1;
                alu_src_b_s    = SRCB_FOUR;
                result_src_s   = RES_ALURESULT;
                cond_capture_s = 1'b1;
                if (!cond_ex_s || !supported_s) begin
                    next_s = FETCH;
                end else begin
                    case (op_s)
                        OP_DP:   next_s = i_bit_s ? EXECUTEI : EXECUTER;
                        OP_MEM:  next_s = MEMADR;
                        OP_BR:   next_s = BRANCH;
                        default: next_s = FETCH;
                    endcase
                end
            end
            EXECUTER, EXECUTEI: begin
                alu_src_b_s = (state_r == EXECUTEI) ? SRCB_IMM : SRCB_REG;
                alu_ctl_s   = dp_alu_s;
                flag_we_s   = cond_ex_r & (s_bit_s | is_cmp_s);
                next_s      = is_cmp_s ? FETCH : ALUWB;
            end
            ALUWB: begin
                reg_write_s = cond_ex_r;
                pc_write_s  = cond_ex_r & rd_pc_s;
                next_s      = FETCH;
            end
            MEMADR: begin
                alu_src_b_s = SRCB_IMM;
                alu_ctl_s   = u_bit_s ? ALU_ADD : ALU_SUB;
                next_s      = l_bit_s ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adr_src_s = 1'b1;
                next_s    = MEMWB;
            end
            MEMWB: begin
                result_src_s = RES_DATA;
                reg_write_s  = cond_ex_r;
                pc_write_s   = cond_ex_r & rd_pc_s;
                next_s       = FETCH;
            end
            MEMWRITE: begin
                adr_src_s   = 1'b1;
                mem_write_s = cond_ex_r;
                next_s      = FETCH;
            end
            BRANCH: begin
                alu_src_b_s  = SRCB_IMM;
                result_src_s = RES_ALURESULT;
                pc_write_s   = 1'b1;
                next_s       = FETCH;
            end
            default: begin
                next_s = FETCH;
            end
        endcase
    end

    // write enables are held off for as long as reset is asserted
    assign bus.PCWrite    = pc_write_s  & ~reset;
    assign bus.MemWrite   = mem_write_s & ~reset;
    assign bus.RegWrite   = reg_write_s & ~reset;
    assign bus.IRWrite    = ir_write_s  & ~reset;
    assign bus.AdrSrc     = adr_src_s;
    assign bus.RegSrc     = {(op_s == OP_MEM) && !l_bit_s, (op_s == OP_BR)};
    assign bus.ALUSrcA    = alu_src_a_s;
    assign bus.ALUSrcB    = alu_src_b_s;
    assign bus.ResultSrc  = result_src_s;
    assign bus.ImmSrc     = imm_src_s;
    assign bus.ALUControl = alu_ctl_s;
    assign bus.StateDbg   = state_r;

endmodule
